// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM states and flag bit positions shared by alu_seq and its bench
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_SHL = 3'd5,
      OP_SHR = 3'd6,
      OP_MUL = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int FLG_Z = 3;
   localparam int FLG_N = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - WIDTH-cycle shift-add unsigned multiplier, instantiated only when ALU_MUL_EN is defined
module alu_mul_iter #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 done,
   output logic [2*WIDTH-1:0]   prod
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH);

   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] w_first;

   // Bit 0 is folded into the load so the product is settled one edge before the WIDTH-th BUSY edge.
   assign w_first = B[0] ? {{WIDTH{1'b0}}, A} : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
      end else if (start) begin
         r_acc    <= w_first;
         r_mcand  <= {{(WIDTH-1){1'b0}}, A, 1'b0};
         r_mplier <= B >> 1;
         r_cnt    <= CW'(1);
      end else if (r_cnt == LAST) begin
         r_cnt    <= '0;
      end else if (r_cnt != '0) begin
         if (r_mplier[0]) r_acc <= r_acc + r_mcand;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
      end
   end

   assign done = (r_cnt == LAST);
   assign prod = r_acc;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered WIDTH-bit ALU with valid/ready handshakes and {Z,N,C,V} flags
// Define ALU_MUL_EN to build the iterative multiplier for op 7; otherwise op 7 returns 0 in one cycle.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic [2:0]         op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   R,
   output logic [3:0]         flags
);

   localparam int SHW = $clog2(WIDTH);

   state_e           r_state;
   state_e           w_next;
   logic             w_accept;
   logic             w_load;
   logic             w_is_mul;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_dif;
   logic [WIDTH-1:0] w_alu_res;
   logic             w_alu_c;
   logic             w_alu_v;
   logic [WIDTH-1:0] w_res;
   logic             w_c;
   logic             w_v;
   logic [3:0]       w_flags;
   logic [WIDTH-1:0] r_R;
   logic [3:0]       r_flags;

`ifdef ALU_MUL_EN
   logic               w_mul_done;
   logic [2*WIDTH-1:0] w_prod;

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk   (clk),
      .rst   (rst),
      .start (w_accept && w_is_mul),
      .A     (A),
      .B     (B),
      .done  (w_mul_done),
      .prod  (w_prod)
   );

   assign w_is_mul = (op_e'(op) == OP_MUL);
   // In BUSY the operand inputs are no longer meaningful, so the result comes only from the multiplier.
   assign w_res = (r_state == BUSY) ? w_prod[WIDTH-1:0] : w_alu_res;
   assign w_c   = (r_state == BUSY) ? |w_prod[2*WIDTH-1:WIDTH] : w_alu_c;
   assign w_v   = (r_state == BUSY) ? 1'b0 : w_alu_v;
`else
   assign w_is_mul = 1'b0;
   assign w_res    = w_alu_res;
   assign w_c      = w_alu_c;
   assign w_v      = w_alu_v;
`endif

   always_comb begin
      w_sum     = {1'b0, A} + {1'b0, B};
      w_dif     = {1'b0, A} - {1'b0, B};
      w_alu_res = '0;
      w_alu_c   = 1'b0;
      w_alu_v   = 1'b0;
      case (op_e'(op))
         OP_ADD: begin
            w_alu_res = w_sum[WIDTH-1:0];
            w_alu_c   = w_sum[WIDTH];
            w_alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            w_alu_res = w_dif[WIDTH-1:0];
            w_alu_c   = w_dif[WIDTH];
            w_alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (w_dif[WIDTH-1] != A[WIDTH-1]);
         end
         OP_AND:  w_alu_res = A & B;
         OP_OR:   w_alu_res = A | B;
         OP_XOR:  w_alu_res = A ^ B;
         OP_SHL:  w_alu_res = A << B[SHW-1:0];
         OP_SHR:  w_alu_res = A >> B[SHW-1:0];
         default: w_alu_res = '0;
      endcase
   end

   always_comb begin
      w_flags        = '0;
      w_flags[FLG_Z] = (w_res == '0);
      w_flags[FLG_N] = w_res[WIDTH-1];
      w_flags[FLG_C] = w_c;
      w_flags[FLG_V] = w_v;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, DONE: begin
            if (w_accept)                            w_next = w_is_mul ? BUSY : DONE;
            else if (r_state == DONE && out_ready)   w_next = IDLE;
         end
`ifdef ALU_MUL_EN
         BUSY: if (w_mul_done) w_next = DONE;
`endif
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
      out_valid = (r_state == DONE);
      w_accept  = in_valid && in_ready;
`ifdef ALU_MUL_EN
      w_load    = (w_accept && !w_is_mul) || ((r_state == BUSY) && w_mul_done);
`else
      w_load    = w_accept;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_R     <= '0;
         r_flags <= '0;
      end else if (w_load) begin
         r_R     <= w_res;
         r_flags <= w_flags;
      end
   end

   assign R     = r_R;
   assign flags = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq (WIDTH=4), optional ALU_MUL_EN build
module tb_alu_seq;
   import alu_pkg::*;

   localparam int W   = 4;
   localparam int SHW = $clog2(W);
`ifdef ALU_MUL_EN
   localparam int MUL_LAT = W + 1;
`else
   localparam int MUL_LAT = 1;
`endif

   typedef struct {
      logic [W-1:0] r;
      logic [3:0]   f;
      int           cyc;
      int           lat;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [2:0]   op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] R;
   logic [3:0]   flags;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   bit   seen = 0;
   bit   rdy_rand = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .R         (R),
      .flags     (flags)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain integer arithmetic on the unsigned/signed values of the operands.
   function automatic exp_t model(input logic [2:0] o, input int a, input int b);
      exp_t e;
      int m   = 1 << W;
      int h   = 1 << (W - 1);
      int sa  = (a >= h) ? a - m : a;
      int sbv = (b >= h) ? b - m : b;
      int r   = 0;
      bit c   = 0;
      bit v   = 0;
      case (o)
         3'd0: begin r = (a + b) % m; c = (a + b) >= m; v = (sa + sbv) >= h || (sa + sbv) < -h; end
         3'd1: begin r = (a - b + m) % m; c = a < b; v = (sa - sbv) >= h || (sa - sbv) < -h; end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = (a << (b % (1 << SHW))) % m;
         3'd6: r = a >> (b % (1 << SHW));
         default: begin
`ifdef ALU_MUL_EN
            r = (a * b) % m;
            c = (a * b) >= m;
`else
            r = 0;
`endif
         end
      endcase
      e.r   = r[W-1:0];
      e.f   = {r == 0, r >= h, c, v};
      e.lat = (o == 3'd7) ? MUL_LAT : 1;
      e.cyc = 0;
      return e;
   endfunction

   // Called at posedge+1; returns at posedge+1 of the accepting edge.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
      exp_t e;
      bit   acc = 0;
      in_valid = 1'b1;
      op = o;
      A = a;
      B = b;
      waited = 0;
      while (!acc && waited < 60) begin
         @(negedge clk);
         if (in_ready === 1'b1) acc = 1;
         else begin
            waited++;
            @(posedge clk);
            #1;
         end
      end
      if (acc) begin
         e = model(o, int'(a), int'(b));
         e.cyc = cyc;
         sb.push_back(e);
         @(posedge clk);
         #1;
      end else begin
         tests++;
         fails++;
         $display("FAIL issue_timeout: in_ready 0 for %0d cycles, expected 1", waited);
      end
      in_valid = 1'b0;
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
   end

   initial forever begin
      @(negedge clk);
      if (rst === 1'b0 && out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL spurious_out_valid: got R=%0h with nothing outstanding, expected out_valid 0", R);
         end else begin
            check("R", R, sb[0].r);
            check("flags", flags, sb[0].f);
            if (!seen) begin
               check("latency", cyc - sb[0].cyc, sb[0].lat);
               seen = 1;
            end
            check("in_ready_while_valid", in_ready, out_ready);
            if (out_ready) begin
               void'(sb.pop_front());
               seen = 0;
            end
         end
      end
   end

   initial begin
      int w;
      int k;
      rst = 1'b1;
      in_valid = 1'b0;
      A = '0;
      B = '0;
      op = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_R", R, 0);
      check("rst_flags", flags, 0);
      check("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;

      issue(OP_ADD, 4'h3, 4'h2, w);
      issue(OP_SUB, 4'h3, 4'h2, w);
      issue(OP_SUB, 4'h2, 4'h3, w);
      issue(OP_ADD, 4'hF, 4'hF, w);
      issue(OP_ADD, 4'h7, 4'h1, w);
      issue(OP_ADD, 4'h3, 4'h2, w);
      issue(OP_SUB, 4'hF, 4'h0, w);
      check("b2b_wait_sub", w, 0);
      issue(OP_XOR, 4'h5, 4'h3, w);
      check("b2b_wait_xor", w, 0);

      @(posedge clk);
      #1;
      out_ready = 1'b0;
      issue(OP_SHL, 4'h3, 4'h1, w);
      fork
         begin
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join_none
      issue(OP_SHR, 4'hC, 4'h2, w);
      check("hold_wait", w, 3);

`ifdef ALU_MUL_EN
      issue(OP_MUL, 4'h5, 4'h3, w);
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         check("mul_busy_in_ready", in_ready, 0);
      end
      @(posedge clk);
      #1;
      issue(OP_MUL, 4'hF, 4'hF, w);
      issue(OP_MUL, 4'h9, 4'h7, w);
      @(negedge clk);
      @(negedge clk);
      #1;
      rst = 1'b1;
      sb.delete();
      seen = 0;
      #1;
`else
      issue(OP_MUL, 4'h9, 4'h4, w);
      issue(OP_ADD, 4'h7, 4'h1, w);
      out_ready = 1'b0;
      @(negedge clk);
      #1;
      rst = 1'b1;
      sb.delete();
      seen = 0;
      #1;
`endif
      check("rst_mid_out_valid", out_valid, 0);
      check("rst_mid_R", R, 0);
      check("rst_mid_flags", flags, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_out_valid", out_valid, 0);
      @(posedge clk);
      #1;

      rdy_rand = 1;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         issue(3'($urandom_range(0, 7)), W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), w);
      end

      rdy_rand = 0;
      out_ready = 1'b1;
      k = 0;
      while (sb.size() != 0 && k < 200) begin
         @(posedge clk);
         k++;
      end
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d results still outstanding, expected 0", sb.size());
      end
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
